// File: rtl/shk_arb_pkg.sv
// Shared types for the shake-bus arbiter: FSM encoding, error flag positions
// and the grant-index width helper.
package shk_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_BUSY = 2'd1,
        ST_RELS = 2'd2,
        ST_LOCK = 2'd3
    } shk_arb_state_e;

    localparam int unsigned ERR_TIMEOUT = 0;
    localparam int unsigned ERR_DROP    = 1;
    localparam int unsigned ERR_STRAY   = 2;

    // Ceiling log2, never less than 1 so a single-bit index always exists.
    function automatic int unsigned shk_log2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/shk_arb_pick.sv
// Combinational master pick: round-robin scan from ptr+1 with wrap, or
// lowest-index priority when SHK_ARB_FIXED_PRIO_EN is defined.
module shk_arb_pick #(
    parameter int unsigned NB_MST = 2,
    parameter int unsigned WD_ID  = 1
) (
    input  logic [NB_MST-1:0] i_valid,
    input  logic [WD_ID-1:0]  i_ptr,
    output logic [WD_ID-1:0]  o_idx,
    output logic              o_found
);

`ifdef SHK_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^i_ptr;

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        // Descending scan: the last hit written is the lowest index.
        for (int unsigned i = NB_MST; i > 0; i--) begin
            if (i_valid[i-1]) begin
                o_idx   = WD_ID'(i - 1);
                o_found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        int unsigned k;
        k       = 0;
        o_idx   = '0;
        o_found = 1'b0;
        // Offsets scanned far-to-near so the nearest one after ptr wins.
        for (int unsigned i = NB_MST; i > 0; i--) begin
            k = (32'(i_ptr) + i) % NB_MST;
            if (i_valid[k]) begin
                o_idx   = WD_ID'(k);
                o_found = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/shk_bus_arb.sv
// Shake-bus arbiter: N masters onto one slave with packet lock, watchdog and
// sticky error flags. Define SHK_ARB_FIXED_PRIO_EN for fixed-priority picking.
module shk_bus_arb
    import shk_arb_pkg::*;
#(
    parameter int unsigned NB_SHK_MST  = 2,
    parameter int unsigned WD_SHK_DATA = 8,
    parameter int unsigned WD_SHK_ADDR = 8,
    parameter int unsigned WD_TIMEOUT  = 20,
    parameter int unsigned WD_ERR_INFO = 4,
    parameter int unsigned WD_MST_ID   = shk_log2(NB_SHK_MST)
) (
    input  logic                            i_sys_clk,
    input  logic                            i_sys_resetn,
    input  logic [NB_SHK_MST-1:0]           s_shk_arb_valid,
    input  logic [NB_SHK_MST-1:0]           s_shk_arb_msync,
    input  logic [NB_SHK_MST*WD_SHK_DATA-1:0] s_shk_arb_mdata,
    input  logic [NB_SHK_MST*WD_SHK_ADDR-1:0] s_shk_arb_maddr,
    output logic [NB_SHK_MST-1:0]           s_shk_arb_ready,
    output logic [NB_SHK_MST-1:0]           s_shk_arb_ssync,
    output logic [WD_SHK_DATA-1:0]          s_shk_arb_sdata,
    output logic [WD_SHK_ADDR-1:0]          s_shk_arb_saddr,
    output logic                            m_shk_arb_valid,
    output logic                            m_shk_arb_msync,
    output logic [WD_SHK_DATA-1:0]          m_shk_arb_mdata,
    output logic [WD_SHK_ADDR-1:0]          m_shk_arb_maddr,
    input  logic                            m_shk_arb_ready,
    input  logic                            m_shk_arb_ssync,
    input  logic [WD_SHK_DATA-1:0]          m_shk_arb_sdata,
    input  logic [WD_SHK_ADDR-1:0]          m_shk_arb_saddr,
    output logic [WD_MST_ID-1:0]            m_arb_grant_id,
    output logic                            m_arb_grant_act,
    input  logic                            i_err_clr,
    output logic [WD_ERR_INFO-1:0]          m_err_arb_info1
);

    shk_arb_state_e         state_q, state_d;
    logic [WD_MST_ID-1:0]   grant_id_q, grant_id_d;
    logic [WD_MST_ID-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WD_TIMEOUT-1:0]  wd_cnt_q, wd_cnt_d;
    logic [WD_ERR_INFO-1:0] err_q, err_d;
    logic                   rdy_q, rdy_d;

    logic [WD_ERR_INFO-1:0] err_set;
    logic                   rdy_edge;
    logic                   routed;
    logic [WD_MST_ID-1:0]   pick_idx;
    logic                   pick_found;
    logic                   own_valid;
    logic                   own_msync;
    logic [WD_SHK_DATA-1:0] own_data;
    logic [WD_SHK_ADDR-1:0] own_addr;

    shk_arb_pick #(
        .NB_MST (NB_SHK_MST),
        .WD_ID  (WD_MST_ID)
    ) u_pick (
        .i_valid (s_shk_arb_valid),
        .i_ptr   (rr_ptr_q),
        .o_idx   (pick_idx),
        .o_found (pick_found)
    );

    assign rdy_d    = m_shk_arb_ready;
    assign rdy_edge = m_shk_arb_ready & ~rdy_q;
    assign routed   = (state_q == ST_BUSY) || (state_q == ST_RELS);

    always_comb begin
        own_valid = 1'b0;
        own_msync = 1'b0;
        own_data  = '0;
        own_addr  = '0;
        for (int unsigned k = 0; k < NB_SHK_MST; k++) begin
            if (grant_id_q == WD_MST_ID'(k)) begin
                own_valid = s_shk_arb_valid[k];
                own_msync = s_shk_arb_msync[k];
                own_data  = s_shk_arb_mdata[k*WD_SHK_DATA +: WD_SHK_DATA];
                own_addr  = s_shk_arb_maddr[k*WD_SHK_ADDR +: WD_SHK_ADDR];
            end
        end
    end

    always_comb begin
        s_shk_arb_ready = '0;
        s_shk_arb_ssync = '0;
        for (int unsigned k = 0; k < NB_SHK_MST; k++) begin
            if (routed && (grant_id_q == WD_MST_ID'(k))) begin
                s_shk_arb_ready[k] = m_shk_arb_ready;
                s_shk_arb_ssync[k] = m_shk_arb_ssync;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        err_set    = '0;
        unique case (state_q)
            ST_ARB: begin
                if (rdy_edge) err_set[ERR_STRAY] = 1'b1;
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rdy_edge) begin
                    state_d = ST_RELS;
                end else if (!own_valid) begin
                    err_set[ERR_DROP] = 1'b1;
                    state_d           = ST_ARB;
                    rr_ptr_d          = grant_id_q;
                end
            end
            ST_RELS: begin
                if (!own_valid && !m_shk_arb_ready) begin
                    if (own_msync) begin
                        state_d = ST_LOCK;
                    end else begin
                        state_d  = ST_ARB;
                        rr_ptr_d = grant_id_q;
                    end
                end
            end
            ST_LOCK: begin
                if (rdy_edge) err_set[ERR_STRAY] = 1'b1;
                if (own_valid) begin
                    state_d = ST_BUSY;
                end else if (!own_msync) begin
                    state_d  = ST_ARB;
                    rr_ptr_d = grant_id_q;
                end
            end
            default: state_d = ST_ARB;
        endcase

        // Watchdog expiry overrides whatever the owner's state would do.
        if (wd_cnt_q[WD_TIMEOUT-1]) begin
            err_set[ERR_TIMEOUT] = 1'b1;
            state_d              = ST_ARB;
            rr_ptr_d             = grant_id_q;
        end

        if ((state_d != state_q) || rdy_edge) begin
            wd_cnt_d = '0;
        end else if (state_q != ST_ARB) begin
            wd_cnt_d = wd_cnt_q + WD_TIMEOUT'(1);
        end else begin
            wd_cnt_d = wd_cnt_q;
        end

        err_d = (err_q & ~{WD_ERR_INFO{i_err_clr}}) | err_set;
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            state_q    <= ST_ARB;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            wd_cnt_q   <= '0;
            err_q      <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            wd_cnt_q   <= wd_cnt_d;
            err_q      <= err_d;
            rdy_q      <= rdy_d;
        end
    end

    assign m_arb_grant_act = (state_q != ST_ARB);
    assign m_arb_grant_id  = grant_id_q;
    assign m_shk_arb_valid = (state_q == ST_BUSY) & own_valid;
    assign m_shk_arb_msync = m_arb_grant_act & own_msync;
    assign m_shk_arb_mdata = m_arb_grant_act ? own_data : '0;
    assign m_shk_arb_maddr = m_arb_grant_act ? own_addr : '0;
    assign s_shk_arb_sdata = m_shk_arb_sdata;
    assign s_shk_arb_saddr = m_shk_arb_saddr;
    assign m_err_arb_info1 = err_q;

endmodule

// File: tb/tb_shk_bus_arb.sv
// Directed bench for shk_bus_arb (2 masters, 6-bit watchdog); expected
// grant orders switch with SHK_ARB_FIXED_PRIO_EN.
module tb_shk_bus_arb;

    localparam int unsigned NB  = 2;
    localparam int unsigned WD  = 8;
    localparam int unsigned WA  = 8;
    localparam int unsigned WT  = 6;
    localparam int unsigned WE  = 4;
    localparam int unsigned WID = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NB-1:0]    s_valid = '0;
    logic [NB-1:0]    s_msync = '0;
    logic [NB*WD-1:0] s_mdata = '0;
    logic [NB*WA-1:0] s_maddr = '0;
    logic [NB-1:0]    s_ready;
    logic [NB-1:0]    s_ssync;
    logic [WD-1:0]    s_sdata;
    logic [WA-1:0]    s_saddr;
    logic             m_valid;
    logic             m_msync;
    logic [WD-1:0]    m_mdata;
    logic [WA-1:0]    m_maddr;
    logic             m_ready = 1'b0;
    logic             m_ssync = 1'b0;
    logic [WD-1:0]    m_sdata = '0;
    logic [WA-1:0]    m_saddr = '0;
    logic [WID-1:0]   grant_id;
    logic             grant_act;
    logic             err_clr = 1'b0;
    logic [WE-1:0]    err;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

`ifdef SHK_ARB_FIXED_PRIO_EN
    int unsigned exp_rr [4] = '{0, 0, 0, 0};
    int unsigned exp_wd_owner = 0;
`else
    int unsigned exp_rr [4] = '{1, 0, 1, 0};
    int unsigned exp_wd_owner = 1;
`endif

    shk_bus_arb #(
        .NB_SHK_MST  (NB),
        .WD_SHK_DATA (WD),
        .WD_SHK_ADDR (WA),
        .WD_TIMEOUT  (WT),
        .WD_ERR_INFO (WE)
    ) dut (
        .i_sys_clk       (clk),
        .i_sys_resetn    (rst_n),
        .s_shk_arb_valid (s_valid),
        .s_shk_arb_msync (s_msync),
        .s_shk_arb_mdata (s_mdata),
        .s_shk_arb_maddr (s_maddr),
        .s_shk_arb_ready (s_ready),
        .s_shk_arb_ssync (s_ssync),
        .s_shk_arb_sdata (s_sdata),
        .s_shk_arb_saddr (s_saddr),
        .m_shk_arb_valid (m_valid),
        .m_shk_arb_msync (m_msync),
        .m_shk_arb_mdata (m_mdata),
        .m_shk_arb_maddr (m_maddr),
        .m_shk_arb_ready (m_ready),
        .m_shk_arb_ssync (m_ssync),
        .m_shk_arb_sdata (m_sdata),
        .m_shk_arb_saddr (m_saddr),
        .m_arb_grant_id  (grant_id),
        .m_arb_grant_act (grant_act),
        .i_err_clr       (err_clr),
        .m_err_arb_info1 (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake: wait for the grant, ack after lat cycles, owner withdraws.
    task automatic xfer(input string tag, input int unsigned exp_id,
                        input int unsigned lat, input logic keep_sync);
        int unsigned    n;
        logic [WID-1:0] own;
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, " latency"}, n, 1);
        check_eq({tag, " grant"}, 32'(grant_id), exp_id);
        own = grant_id;
        repeat (lat) tick();
        m_ready = 1'b1;
        #1;
        check_eq({tag, " s_ready"}, 32'(s_ready), 32'(1) << exp_id);
        tick();
        s_valid[own] = 1'b0;
        s_msync[own] = keep_sync;
        m_ready      = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset m_valid", m_valid, 0);
        check_eq("reset s_ready", s_ready, 0);
        check_eq("reset grant", {grant_act, grant_id}, 0);
        check_eq("reset err", err, 0);
        rst_n = 1'b1;
        tick();

        // single master
        s_mdata = 16'h00A5;
        s_maddr = 16'h0011;
        s_valid = 2'b01;
        #1;
        check_eq("t1 pre valid", m_valid, 0);
        tick();
        check_eq("t1 m_valid", m_valid, 1);
        check_eq("t1 grant", {grant_act, grant_id}, 2'b10);
        check_eq("t1 mdata", m_mdata, 8'hA5);
        check_eq("t1 maddr", m_maddr, 8'h11);
        repeat (4) tick();
        m_ready = 1'b1;
        m_ssync = 1'b1;
        m_sdata = 8'h3C;
        #1;
        check_eq("t1 s_ready", s_ready, 2'b01);
        check_eq("t1 s_ssync", s_ssync, 2'b01);
        check_eq("t1 s_sdata", s_sdata, 8'h3C);
        tick();
        check_eq("t1 rels s_ready", s_ready, 2'b01);
        s_valid = 2'b00;
        m_ready = 1'b0;
        m_ssync = 1'b0;
        tick();
        check_eq("t1 released", grant_act, 0);
        check_eq("t1 err", err, 0);

        // two masters contending, pointer at 0
        s_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            xfer("rr", exp_rr[i], 1, 1'b0);
            s_valid = 2'b11;
        end
        s_valid = 2'b00;

        // packet lock held by m1 across four transfers
        s_valid = 2'b10;
        s_msync = 2'b10;
        xfer("lock0", 1, 2, 1'b1);
        s_valid[0] = 1'b1;
        check_eq("lock act", grant_act, 1);
        check_eq("lock id", grant_id, 1);
        check_eq("lock m_valid", m_valid, 0);
        tick();
        check_eq("lock hold id", {grant_act, grant_id}, 2'b11);
        for (int i = 1; i < 4; i++) begin
            s_valid[1] = 1'b1;
            xfer("lockn", 1, 2, (i < 3) ? 1'b1 : 1'b0);
        end
        xfer("lock m0", 0, 2, 1'b0);
        s_valid = 2'b00;
        s_msync = 2'b00;

        // watchdog: owner stalls, slave never readies
        s_valid = 2'b01;
        tick();
        check_eq("wd owner", {grant_act, grant_id}, 2'b10);
        s_valid = 2'b11;
        repeat (32) tick();
        check_eq("wd before act", grant_act, 1);
        check_eq("wd before err", err, 0);
        tick();
        check_eq("wd fire err", err, 4'b0001);
        check_eq("wd fire act", grant_act, 0);
        tick();
        check_eq("wd new act", grant_act, 1);
        check_eq("wd new owner", grant_id, exp_wd_owner);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("wd err clr", err, 0);
        m_ready = 1'b1;
        tick();
        s_valid = 2'b00;
        m_ready = 1'b0;
        tick();
        check_eq("wd done", grant_act, 0);

        // owner withdraws valid before ready
        s_valid = 2'b01;
        tick();
        check_eq("drop m_valid", m_valid, 1);
        s_valid = 2'b00;
        tick();
        check_eq("drop err", err, 4'b0010);
        check_eq("drop act", grant_act, 0);
        check_eq("drop m_valid low", m_valid, 0);

        // stray ready in ARB coinciding with clear: new flag survives
        m_ready = 1'b1;
        err_clr = 1'b1;
        #1;
        check_eq("stray s_ready", s_ready, 0);
        tick();
        m_ready = 1'b0;
        err_clr = 1'b0;
        check_eq("stray err", err, 4'b0100);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("stray clr", err, 0);

        // asynchronous reset in the middle of a transfer
        s_mdata = 16'h005A;
        s_valid = 2'b01;
        tick();
        check_eq("rst pre m_valid", m_valid, 1);
        m_ready = 1'b1;
        #1;
        check_eq("rst pre s_ready", s_ready, 2'b01);
        rst_n = 1'b0;
        #1;
        check_eq("rst m_valid", m_valid, 0);
        check_eq("rst s_ready", s_ready, 0);
        check_eq("rst mdata", m_mdata, 0);
        check_eq("rst grant", {grant_act, grant_id}, 0);
        check_eq("rst err", err, 0);
        m_ready = 1'b0;
        s_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
